// File: rtl/mm2s_run_ctrl.sv
// Run controller for the mm2s read engine: latches a descriptor set and issues
// back-to-back start commands, stepping every channel address by a stride per run.
module mm2s_run_ctrl #(
  parameter int ADDR_WIDTH = 64,
  parameter int N_CHANNELS = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_addr [N_CHANNELS],
  input  logic [ADDR_WIDTH-1:0] cfg_size [N_CHANNELS],
  input  logic [N_CHANNELS-1:0] cfg_chan_en,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [CNT_WIDTH-1:0]  cfg_iterations,
  input  logic                  cfg_go,
  input  logic                  cfg_abort,
  output logic [ADDR_WIDTH-1:0] rd_addr [N_CHANNELS],
  output logic [ADDR_WIDTH-1:0] rd_size [N_CHANNELS],
  output logic                  start,
  input  logic                  core_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [CNT_WIDTH-1:0]  iter_count,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  go_err,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_GUARD     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_NEXT      = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr [N_CHANNELS];
  logic [ADDR_WIDTH-1:0] r_size [N_CHANNELS];
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [CNT_WIDTH-1:0]  r_iters;
  logic [CNT_WIDTH-1:0]  r_iter_count;
  logic [CNT_WIDTH-1:0]  r_cycle_count;
  logic                  r_abort;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_go_err;
  logic                  r_guard;

  logic [CNT_WIDTH-1:0]  w_iter_next;
  logic                  w_last;
  logic                  w_abort_seen;

  assign w_iter_next  = r_iter_count + CNT_WIDTH'(1);
  assign w_last       = (r_iters != '0) && (w_iter_next == r_iters);
  assign w_abort_seen = r_abort | cfg_abort;

  // Handshake: start is a single-cycle command accepted by mm2s only while
  // core_ready is high, so it is qualified combinationally by core_ready in
  // LAUNCH; completion is core_ready returning high after the guard window.
  assign start = (r_state == S_LAUNCH) && core_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_stride      <= '0;
      r_iters       <= '0;
      r_iter_count  <= '0;
      r_cycle_count <= '0;
      r_abort       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_go_err      <= 1'b0;
      r_guard       <= 1'b0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        r_addr[i] <= '0;
        r_size[i] <= '0;
      end
    end else begin
      r_done   <= 1'b0;
      r_go_err <= 1'b0;
      if (r_busy && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
      if (r_state != S_IDLE) begin
        if (cfg_go)    r_go_err <= 1'b1;
        if (cfg_abort) r_abort  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_go) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
              r_addr[i] <= cfg_addr[i];
              r_size[i] <= cfg_chan_en[i] ? cfg_size[i] : '0;
            end
            r_stride      <= cfg_stride;
            r_iters       <= cfg_iterations;
            r_iter_count  <= '0;
            r_cycle_count <= '0;
            r_aborted     <= 1'b0;
            r_abort       <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (core_ready) begin
            r_guard <= 1'b0;
            r_state <= S_GUARD;
          end
        end
        S_GUARD: begin
          // mm2s drops core_ready two cycles after start; ignore it until then.
          if (r_guard) r_state <= S_WAIT_DONE;
          else         r_guard <= 1'b1;
        end
        S_WAIT_DONE: begin
          if (core_ready) begin
            r_iter_count <= w_iter_next;
            r_state      <= S_NEXT;
            if (w_abort_seen || w_last) begin
              r_done    <= 1'b1;
              r_aborted <= w_abort_seen;
            end
          end
        end
        S_NEXT: begin
          // The finish decision was taken on the completing edge so that done
          // is a registered pulse in this cycle; an abort arriving now ends
          // the job after the run that is about to launch.
          if (r_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            for (int i = 0; i < N_CHANNELS; i++)
              r_addr[i] <= r_addr[i] + r_stride;
            r_state <= S_LAUNCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_addr     = r_addr;
  assign rd_size     = r_size;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;
  assign go_err      = r_go_err;
  assign iter_count  = r_iter_count;
  assign cycle_count = r_cycle_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mm2s_run_ctrl.sv
// Bench for mm2s_run_ctrl: table of jobs against a small mm2s core_ready model,
// plus hand-written sequences for abort, stalled launch, go_err and reset.
module tb_mm2s_run_ctrl;
  localparam int AW = 64;
  localparam int NC = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_addr [NC];
  logic [AW-1:0] cfg_size [NC];
  logic [NC-1:0] cfg_chan_en;
  logic [AW-1:0] cfg_stride;
  logic [CW-1:0] cfg_iterations;
  logic          cfg_go;
  logic          cfg_abort;
  logic [AW-1:0] rd_addr [NC];
  logic [AW-1:0] rd_size [NC];
  logic          start;
  logic          core_ready;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] iter_count;
  logic [CW-1:0] cycle_count;
  logic          go_err;
  logic [2:0]    dbg_state;

  mm2s_run_ctrl #(.ADDR_WIDTH(AW), .N_CHANNELS(NC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_size(cfg_size), .cfg_chan_en(cfg_chan_en),
    .cfg_stride(cfg_stride), .cfg_iterations(cfg_iterations),
    .cfg_go(cfg_go), .cfg_abort(cfg_abort),
    .rd_addr(rd_addr), .rd_size(rd_size), .start(start),
    .core_ready(core_ready), .busy(busy), .done(done), .aborted(aborted),
    .iter_count(iter_count), .cycle_count(cycle_count), .go_err(go_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- mm2s core_ready model ----------------
  // core_ready stays high for 2 cycles after start, is low from cycle 3 and
  // returns high `lat` cycles after start.
  int   lat = 5;
  int   mdl_k = 0;
  logic mdl_active = 1'b0;
  logic hold_low = 1'b0;

  always @(posedge clk) begin
    if (start) begin
      mdl_active <= 1'b1;
      mdl_k      <= 1;
    end else if (mdl_active && mdl_k < 100000) begin
      mdl_k <= mdl_k + 1;
    end
  end

  always_comb core_ready = !hold_low && (!mdl_active || mdl_k < 3 || mdl_k >= lat);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int done_cnt = 0;
  int goerr_cnt = 0;
  logic [AW-1:0] exp_base [NC];
  logic [AW-1:0] exp_size [NC];
  logic [AW-1:0] exp_stride = '0;
  logic [AW-1:0] last_addr0 = '0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && start) begin
      check("start_needs_core_ready", core_ready, 1);
      for (int i = 0; i < NC; i++) begin
        check($sformatf("rd_addr[%0d] run %0d", i, starts), rd_addr[i],
              exp_base[i] + AW'(starts) * exp_stride);
        check($sformatf("rd_size[%0d] run %0d", i, starts), rd_size[i], exp_size[i]);
      end
      last_addr0 = rd_addr[0];
      starts++;
    end
    if (done)   done_cnt++;
    if (go_err) goerr_cnt++;
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] iters;
    logic [NC-1:0] en;
    logic [AW-1:0] size;
    int            lat;
    int            exp_starts;
    int            exp_cycles;
    logic [AW-1:0] exp_last_addr;
  } job_t;

  job_t jobs [4];

  task automatic setup_job(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input logic [CW-1:0] iters, input logic [NC-1:0] en,
                           input logic [AW-1:0] size, input int l);
    for (int i = 0; i < NC; i++) begin
      cfg_addr[i] = base + (AW'(i) << 16);
      cfg_size[i] = size;
      exp_base[i] = base + (AW'(i) << 16);
      exp_size[i] = en[i] ? size : '0;
    end
    cfg_chan_en    = en;
    cfg_stride     = stride;
    cfg_iterations = iters;
    exp_stride     = stride;
    lat            = l;
    starts         = 0;
    done_cnt       = 0;
    goerr_cnt      = 0;
  endtask

  // Changes the live config after launch; the job must keep its snapshot.
  task automatic scramble_cfg();
    for (int i = 0; i < NC; i++) begin
      cfg_addr[i] = 64'hDEAD_0000 + AW'(i);
      cfg_size[i] = 64'h777;
    end
    cfg_chan_en    = ~cfg_chan_en;
    cfg_stride     = 64'h5555;
    cfg_iterations = 32'd9;
  endtask

  task automatic pulse_go(input logic with_abort);
    @(negedge clk);
    cfg_go    = 1'b1;
    cfg_abort = with_abort;
    @(negedge clk);
    cfg_go    = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (starts < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("starts_reached", starts, target);
  endtask

  // ---------------- test ----------------
  initial begin
    jobs[0] = '{64'h1000_0000, 64'h100, 32'd1, 4'b0011, 64'd8192, 40, 1, 42, 64'h1000_0000};
    jobs[1] = '{64'h1000, 64'h2000, 32'd3, 4'b1111, 64'd256, 5, 3, 21, 64'h5000};
    jobs[2] = '{64'hFFFF_FFFF_FFFF_F000, 64'h1000, 32'd2, 4'b0101, 64'd64, 4, 2, 12, 64'h0};
    jobs[3] = '{64'h8000, 64'h40, 32'd2, 4'b0000, 64'd4096, 2, 2, 10, 64'h8040};

    rst = 1'b1;
    cfg_go = 1'b0;
    cfg_abort = 1'b0;
    setup_job('0, '0, '0, '0, '0, 5);
    repeat (3) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst aborted", aborted, 0);
    check("rst go_err", go_err, 0);
    check("rst start", start, 0);
    check("rst iter_count", iter_count, 0);
    check("rst cycle_count", cycle_count, 0);
    check("rst state", dbg_state, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int j = 0; j < 4; j++) begin
      setup_job(jobs[j].base, jobs[j].stride, jobs[j].iters, jobs[j].en,
                jobs[j].size, jobs[j].lat);
      pulse_go(1'b0);
      check($sformatf("job%0d busy_after_go", j), busy, 1);
      scramble_cfg();
      wait_done();
      check($sformatf("job%0d iter_count", j), iter_count, AW'(jobs[j].exp_starts));
      check($sformatf("job%0d aborted", j), aborted, 0);
      @(negedge clk);
      check($sformatf("job%0d busy_clear", j), busy, 0);
      check($sformatf("job%0d cycle_count", j), cycle_count, AW'(jobs[j].exp_cycles));
      check($sformatf("job%0d starts", j), AW'(starts), AW'(jobs[j].exp_starts));
      check($sformatf("job%0d done_count", j), AW'(done_cnt), 1);
      check($sformatf("job%0d go_err_count", j), AW'(goerr_cnt), 0);
      check($sformatf("job%0d last_addr0", j), last_addr0, jobs[j].exp_last_addr);
      repeat (3) @(negedge clk);
    end

    // Stalled launch, with an abort in the same cycle as go (ignored in IDLE).
    setup_job(64'h4000, 64'h0, 32'd1, 4'b0001, 64'd512, 6);
    hold_low = 1'b1;
    pulse_go(1'b1);
    repeat (5) @(negedge clk);
    check("hold no_start", AW'(starts), 0);
    check("hold state_launch", dbg_state, 1);
    hold_low = 1'b0;
    wait_done();
    check("hold iter_count", iter_count, 1);
    check("hold aborted", aborted, 0);
    @(negedge clk);
    check("hold cycle_count", cycle_count, 13);
    check("hold starts", AW'(starts), 1);
    repeat (3) @(negedge clk);

    // Continuous mode, go while busy during run 2, abort during run 5.
    setup_job(64'h2_0000, 64'h800, 32'd0, 4'b1111, 64'd1024, 10);
    pulse_go(1'b0);
    scramble_cfg();
    wait_starts(2);
    repeat (4) @(negedge clk);
    pulse_go(1'b0);
    wait_starts(5);
    repeat (4) @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    wait_done();
    check("abort iter_count", iter_count, 5);
    check("abort aborted_at_done", aborted, 1);
    @(negedge clk);
    check("abort busy_clear", busy, 0);
    check("abort cycle_count", cycle_count, 60);
    repeat (30) @(negedge clk);
    check("abort starts", AW'(starts), 5);
    check("abort aborted_held", aborted, 1);
    check("abort go_err_count", AW'(goerr_cnt), 1);
    check("abort done_count", AW'(done_cnt), 1);

    // Reset in the middle of WAIT_DONE of run 2.
    setup_job(64'h9_0000, 64'h100, 32'd3, 4'b0110, 64'd2048, 30);
    pulse_go(1'b0);
    wait_starts(2);
    repeat (10) @(negedge clk);
    check("pre_rst state_wait", dbg_state, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst aborted", aborted, 0);
    check("midrst go_err", go_err, 0);
    check("midrst start", start, 0);
    check("midrst iter_count", iter_count, 0);
    check("midrst cycle_count", cycle_count, 0);
    check("midrst state", dbg_state, 0);
    for (int i = 0; i < NC; i++) begin
      check($sformatf("midrst rd_addr[%0d]", i), rd_addr[i], 0);
      check($sformatf("midrst rd_size[%0d]", i), rd_size[i], 0);
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("postrst starts", AW'(starts), 2);
    check("postrst busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
